// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between pipeline WB and a buffered mul/div result FIFO
module wb_port_arbiter #(
    parameter int DATA_WIDTH          = 32,
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH          = 4,
    parameter int STARVE_LIMIT        = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                reg_write_WB,
    input  logic [REGISTER_ADDR_WIDTH-1:0]      rd_WB,
    input  logic [DATA_WIDTH-1:0]               result_WB,
    input  logic                                md_valid,
    input  logic [REGISTER_ADDR_WIDTH-1:0]      md_rd,
    input  logic [DATA_WIDTH-1:0]               md_result,
    output logic                                md_ready,
    output logic                                rf_we,
    output logic [REGISTER_ADDR_WIDTH-1:0]      rf_waddr,
    output logic [DATA_WIDTH-1:0]               rf_wdata,
    output logic                                md_grant,
    output logic [2**REGISTER_ADDR_WIDTH-1:0]   md_pending_mask,
    output logic                                stall_req,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_count
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int NREG     = 2**REGISTER_ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    // Buffered mul/div results; storage is not reset, validity comes from pointers/count
    logic [REGISTER_ADDR_WIDTH-1:0] r_rd_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]          r_data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]    r_rptr;
    logic [PTR_W-1:0]    r_wptr;
    logic [CNT_W-1:0]    r_count;
    logic [STARVE_W-1:0] r_starve;
    state_t              r_state;

    logic                w_pipe_we;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [CNT_W-1:0]    w_count_next;
    logic [STARVE_W-1:0] w_starve_next;
    state_t              w_state_next;
    logic [NREG-1:0]     w_mask;

    // A pipeline write to x0 is architecturally a no-op, so it leaves the port free
    assign w_pipe_we = reg_write_WB && (rd_WB != '0);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));

    // Results to x0 complete the handshake but are never stored
    assign md_ready  = !rst && !w_full;
    assign w_push    = md_valid && md_ready && (md_rd != '0);
    assign md_grant  = !rst && !w_pipe_we && !w_empty;
    assign w_pop     = md_grant;

    assign fifo_count      = r_count;
    assign stall_req       = (r_state == S_FORCE);
    assign md_pending_mask = w_mask;

    // Write-port mux: pipeline first, FIFO head only in otherwise idle cycles
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!rst) begin
            if (w_pipe_we) begin
                rf_we    = 1'b1;
                rf_waddr = rd_WB;
                rf_wdata = result_WB;
            end else if (!w_empty) begin
                rf_we    = 1'b1;
                rf_waddr = r_rd_mem[r_rptr];
                rf_wdata = r_data_mem[r_rptr];
            end
        end
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // Saturating count of cycles a buffered result was denied the port
    always_comb begin
        w_starve_next = '0;
        if (!w_empty && !md_grant) begin
            if (r_starve == STARVE_W'(STARVE_LIMIT)) begin
                w_starve_next = r_starve;
            end else begin
                w_starve_next = r_starve + STARVE_W'(1);
            end
        end
    end

    // Pending-rd mask: one-hot rd of every occupied slot, walking offsets from the read pointer
    always_comb begin
        logic [PTR_W-1:0] v_offs;
        w_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            v_offs = PTR_W'(i) - r_rptr;
            if ({1'b0, v_offs} < r_count) begin
                w_mask[r_rd_mem[i]] = 1'b1;
            end
        end
        w_mask[0] = 1'b0;
    end

    // Starvation FSM next-state: FORCE holds the bubble request until the head is written
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_count_next != '0) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_count_next == '0) begin
                    w_state_next = S_IDLE;
                end else if (w_starve_next == STARVE_W'(STARVE_LIMIT)) begin
                    w_state_next = S_FORCE;
                end
            end
            S_FORCE: begin
                if (md_grant) begin
                    w_state_next = (w_count_next != '0) ? S_WAIT : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FIFO data storage write on accepted nonzero-rd results
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_mem[r_wptr]   <= md_rd;
            r_data_mem[r_wptr] <= md_result;
        end
    end

    // Control state: pointers, occupancy, starvation counter, FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr   <= '0;
            r_wptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_state  <= S_IDLE;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count  <= w_count_next;
            r_starve <= w_starve_next;
            r_state  <= w_state_next;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter with a queue-based reference model
module tb_wb_port_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic          clk;
    logic          rst;
    logic          reg_write_WB;
    logic [AW-1:0] rd_WB;
    logic [DW-1:0] result_WB;
    logic          md_valid;
    logic [AW-1:0] md_rd;
    logic [DW-1:0] md_result;
    logic          md_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          md_grant;
    logic [31:0]   md_pending_mask;
    logic          stall_req;
    logic [2:0]    fifo_count;

    wb_port_arbiter #(
        .DATA_WIDTH(DW), .REGISTER_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .reg_write_WB(reg_write_WB), .rd_WB(rd_WB), .result_WB(result_WB),
        .md_valid(md_valid), .md_rd(md_rd), .md_result(md_result), .md_ready(md_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .md_grant(md_grant),
        .md_pending_mask(md_pending_mask), .stall_req(stall_req), .fifo_count(fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered results as a plain queue plus a denied-cycle counter
    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t q[$];
    int   starve = 0;

    always @(posedge clk) begin
        bit   pipe;
        bit   grant;
        bit   ready;
        bit   had;
        ent_t e;
        if (rst) begin
            q.delete();
            starve = 0;
        end else begin
            pipe  = reg_write_WB && (rd_WB != 0);
            had   = (q.size() > 0);
            grant = !pipe && had;
            ready = (q.size() < DEPTH);
            if (grant) void'(q.pop_front());
            if (grant || !had) starve = 0;
            else if (starve < LIMIT) starve = starve + 1;
            if (md_valid && ready && md_rd != 0) begin
                e.rd   = md_rd;
                e.data = md_result;
                q.push_back(e);
            end
        end
    end

    // Every-cycle comparison of the DUT against the model, mid-cycle
    always @(negedge clk) begin
        bit            pipe;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic [31:0]   e_mask;
        if (rst) begin
            check("rst_md_ready", md_ready, 0);
            check("rst_rf_we", rf_we, 0);
            check("rst_md_grant", md_grant, 0);
        end else begin
            pipe   = reg_write_WB && (rd_WB != 0);
            e_we   = pipe || (q.size() > 0);
            e_addr = pipe ? rd_WB : (q.size() > 0 ? q[0].rd : '0);
            e_data = pipe ? result_WB : (q.size() > 0 ? q[0].data : '0);
            e_mask = '0;
            foreach (q[i]) e_mask[q[i].rd] = 1'b1;
            e_mask[0] = 1'b0;
            check("rf_we", rf_we, e_we);
            check("rf_waddr", rf_waddr, e_addr);
            check("rf_wdata", rf_wdata, e_data);
            check("md_grant", md_grant, !pipe && (q.size() > 0));
            check("md_ready", md_ready, q.size() != DEPTH);
            check("fifo_count", fifo_count, q.size());
            check("pending_mask", md_pending_mask, e_mask);
            check("stall_req", stall_req, starve == LIMIT);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setin(input logic rw, input logic [AW-1:0] rdw, input logic [DW-1:0] res,
                         input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mres);
        reg_write_WB = rw;
        rd_WB        = rdw;
        result_WB    = res;
        md_valid     = mv;
        md_rd        = mrd;
        md_result    = mres;
    endtask

    initial begin
        int busy_pct;
        rst = 1'b1;
        setin(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        #2 check("lit_rst_ready", md_ready, 0);
        tick();
        rst = 1'b0;
        #2;
        check("lit_reset_count", fifo_count, 0);
        check("lit_reset_stall", stall_req, 0);
        check("lit_reset_mask", md_pending_mask, 0);
        check("lit_reset_we", rf_we, 0);

        // Single result with idle pipeline
        tick();
        setin(0, 0, 0, 1, 5, 32'hDEADBEEF);
        #2 check("lit_t1_ready", md_ready, 1);
        tick();
        setin(0, 0, 0, 0, 0, 0);
        #2;
        check("lit_t1_we", rf_we, 1);
        check("lit_t1_addr", rf_waddr, 5);
        check("lit_t1_data", rf_wdata, 32'hDEADBEEF);
        check("lit_t1_grant", md_grant, 1);
        check("lit_t1_mask", md_pending_mask, 32'h20);
        tick();
        #2;
        check("lit_t1_mask_clr", md_pending_mask, 0);
        check("lit_t1_count", fifo_count, 0);

        // Starvation behind a continuously busy pipeline
        tick();
        setin(1, 3, 32'h11, 1, 7, 32'h77);
        tick();
        setin(1, 3, 32'h11, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            #2 check("lit_t2_addr", rf_waddr, 3);
            if (k == 8) check("lit_t2_stall_lo", stall_req, 0);
            if (k == 9) check("lit_t2_stall_hi", stall_req, 1);
            tick();
        end
        setin(0, 0, 0, 0, 0, 0);
        #2 check("lit_t2_drain_addr", rf_waddr, 7);
        tick();
        setin(1, 3, 32'h11, 0, 0, 0);
        #2 check("lit_t2_stall_drop", stall_req, 0);
        tick();

        // Fill to full, then drain in order
        for (int i = 1; i <= 4; i++) begin
            setin(1, 3, 32'h11, 1, AW'(i), 32'h100 + i);
            tick();
        end
        setin(1, 3, 32'h11, 0, 0, 0);
        #2;
        check("lit_t3_count", fifo_count, 4);
        check("lit_t3_ready", md_ready, 0);
        check("lit_t3_mask", md_pending_mask, 32'h1E);
        tick();
        setin(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            #2 check("lit_t3_order", rf_waddr, i);
            if (i == 2) check("lit_t3_ready_back", md_ready, 1);
            tick();
        end

        // Pipeline write to x0 leaves the port to the FIFO; md_rd=0 is accepted but dropped
        setin(1, 3, 32'h11, 1, 9, 32'h99);
        tick();
        setin(1, 0, 32'h55, 1, 0, 32'hAA);
        #2;
        check("lit_t4_grant", md_grant, 1);
        check("lit_t4_addr", rf_waddr, 9);
        check("lit_t4_ready", md_ready, 1);
        tick();
        setin(0, 0, 0, 0, 0, 0);
        #2 check("lit_t4_count", fifo_count, 0);
        tick();

        // Steady push+pop at occupancy 2 across several pointer wraps
        setin(1, 3, 32'h11, 1, 10, 32'hA0);
        tick();
        setin(1, 3, 32'h11, 1, 11, 32'hB0);
        tick();
        for (int i = 0; i < 12; i++) begin
            setin(0, 0, 0, 1, AW'(12 + i), 32'hC00 + i);
            #2 check("lit_t5_count", fifo_count, 2);
            tick();
        end
        setin(0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        // Reset while three entries wait in FORCE
        for (int i = 0; i < 3; i++) begin
            setin(1, 3, 32'h11, 1, AW'(20 + i), 32'hD00 + i);
            tick();
        end
        setin(1, 3, 32'h11, 0, 0, 0);
        repeat (10) tick();
        #2 check("lit_t6_stall_pre", stall_req, 1);
        tick();
        rst = 1'b1;
        setin(1, 4, 32'h44, 1, 6, 32'h66);
        #2;
        check("lit_t6_rst_ready", md_ready, 0);
        check("lit_t6_rst_we", rf_we, 0);
        tick();
        rst = 1'b0;
        setin(1, 4, 32'h44, 0, 0, 0);
        #2;
        check("lit_t6_count", fifo_count, 0);
        check("lit_t6_stall", stall_req, 0);
        check("lit_t6_mask", md_pending_mask, 0);
        check("lit_t6_we", rf_we, 1);
        check("lit_t6_addr", rf_waddr, 4);
        tick();
        setin(0, 0, 0, 0, 0, 0);
        #2 check("lit_t6_idle_we", rf_we, 0);
        tick();

        // Randomized traffic with varying pipeline load and occasional resets
        busy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0: busy_pct = 20;
                    1: busy_pct = 60;
                    default: busy_pct = 97;
                endcase
            end
            rst = ($urandom_range(0, 299) == 0);
            setin($urandom_range(0, 99) < busy_pct,
                  ($urandom_range(0, 9) == 0) ? AW'(0) : AW'($urandom_range(1, 31)),
                  $urandom(),
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 9) == 0) ? AW'(0) : AW'($urandom_range(1, 31)),
                  $urandom());
            tick();
        end
        rst = 1'b0;
        setin(0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writers:
  - the in-order pipeline WB stage (reg_write_WB/rd_WB/result_WB);
  - the long-latency mul/div unit, whose results arrive out of pipeline order.
- Pipeline WB always has priority and is never stalled by this block.
- Mul/div results are held in a small FIFO and drained into idle write-port cycles.
- A starvation FSM asks the hazard unit for bubbles, and a pending-rd mask lets the hazard unit block dependent instructions.

Parameters:
- DATA_WIDTH, 32, register data width.
- REGISTER_ADDR_WIDTH, 5, register index width.
- FIFO_DEPTH, 4, mul/div result buffer entries; power of 2, ≥2.
- STARVE_LIMIT, 8, consecutive denied cycles before stall_req; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- reg_write_WB  in  1  pipeline WB write enable.
- rd_WB  in  REGISTER_ADDR_WIDTH  pipeline WB destination register.
- result_WB  in  DATA_WIDTH  pipeline WB write data.
- md_valid  in  1  mul/div result valid.
- md_rd  in  REGISTER_ADDR_WIDTH  mul/div destination register.
- md_result  in  DATA_WIDTH  mul/div result.
- md_ready  out  1  arbiter can accept a mul/div result.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REGISTER_ADDR_WIDTH  register-file write address.
- rf_wdata  out  DATA_WIDTH  register-file write data.
- md_grant  out  1  FIFO head is being written this cycle.
- md_pending_mask  out  2**REGISTER_ADDR_WIDTH  one bit per rd held in the FIFO.
- stall_req  out  1  request to the hazard unit to inject a WB bubble.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (rst high at a clock edge):
  - fifo_count=0, read/write pointers=0, starve_cnt=0, FSM=IDLE.
  - stall_req=0, md_pending_mask=0.
  - While rst is high: md_ready=0, rf_we=0, md_grant=0.
  - Reset mid-drain discards all buffered results.
- pipe_we = reg_write_WB && (rd_WB != 0). A write to x0 counts as an idle port.
- Port mux (combinational, zero latency):
  - pipe_we=1: rf_we=1, rf_waddr=rd_WB, rf_wdata=result_WB, md_grant=0.
  - Else if FIFO non-empty: md_grant=1, rf_we=1, write address/data = FIFO head rd/data.
  - Else: rf_we=0, rf_waddr=0, rf_wdata=0.
- Enqueue handshake:
  - md_ready = !rst && (fifo_count != FIFO_DEPTH).
  - Transfer occurs when md_valid && md_ready at a clock edge.
  - md_rd==0 is accepted but not enqueued.
  - No bypass: an accepted result can be written to the register file no earlier than the next cycle (minimum latency 1).
- Dequeue: md_grant pops the head at the clock edge.
- Occupancy and pointers:
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Push is impossible when full (md_ready=0).
  - Pop is impossible when empty.
  - Pointers wrap modulo FIFO_DEPTH.
  - Entries drain in FIFO order.
- md_pending_mask:
  - OR of one-hot(rd) over valid FIFO entries, taken from registered state.
  - Bit 0 is always 0.
  - A bit clears the cycle after its entry's grant, unless another valid entry holds the same rd.
- starve_cnt:
  - Increments each cycle the FIFO is non-empty and md_grant=0.
  - Clears on md_grant or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- FSM (registered):
  - IDLE: FIFO empty. Go to WAIT on the first enqueue.
  - WAIT: FIFO non-empty, stall_req=0. Go to FORCE when the next-cycle starve_cnt equals STARVE_LIMIT.
  - FORCE: stall_req=1.
    - On md_grant: go to WAIT if entries remain after the pop, else IDLE.
    - stall_req drops the cycle after the grant edge.
  - From WAIT, a pop that empties the FIFO with no same-cycle push goes to IDLE.
- WAW and RAW ordering across the two writers is the hazard unit's job, using md_pending_mask. This block never reorders, merges or drops nonzero-rd entries.

Test Plan:
- md_valid=1, md_rd=5, md_result=0xDEAD_BEEF with pipeline idle:
  - cycle 0: md_ready=1, accepted.
  - cycle 1: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, md_grant=1, md_pending_mask[5]=1.
  - cycle 2: mask=0, fifo_count=0.
- Pipeline writes rd_WB=3 / 0x11 every cycle while one mul/div result to rd=7 is buffered:
  - rf_waddr=3 every cycle; stall_req rises after 8 denied cycles.
  - Drop reg_write_WB for one cycle: rd=7 is written, and stall_req=0 the following cycle.
- Push 4 results to rd=1..4 with pipeline busy:
  - fifo_count=4, md_ready=0, mask=0x1E.
  - Free the port: writes drain in order 1, 2, 3, 4; md_ready returns 1 after the first pop.
- reg_write_WB=1 with rd_WB=0 while FIFO holds rd=9:
  - Mul/div entry is granted (rf_waddr=9).
  - md_rd=0 input is accepted with fifo_count unchanged.
- Simultaneous push and pop at fifo_count=2: fifo_count stays 2, ordering preserved across pointer wrap over 10+ entries.
- Assert rst while FIFO holds 3 entries and FSM=FORCE:
  - Next cycle fifo_count=0, stall_req=0, mask=0, rf_we follows the pipeline only.
  - md_ready=0 during rst.
